// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   OP_ADD / OP_SUB : encoding of the 'sub' operation select input
//   seg_width()     : segment width handled by one pipeline stage
//   geometry_ok()   : legal NBIT/STAGES combination (checked at elaboration)
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits resolved per pipeline stage.
  function automatic int seg_width(input int nbit, input int stages);
    return nbit / stages;
  endfunction

  // Stages must split the operand into equal, non-empty segments.
  function automatic bit geometry_ok(input int nbit, input int stages);
    return (stages >= 1) && (stages <= nbit) && ((nbit % stages) == 0);
  endfunction

endpackage

// File: rtl/cla_seg.sv
// -----------------------------------------------------------------------------
// cla_seg
// Combinational SEG-bit carry-lookahead segment. Every carry is a flat
// sum-of-products of generate/propagate terms and the segment carry-in, so
// there is no ripple path through the segment.
//   a, b  : segment operands (b is already inverted for subtraction)
//   ci    : carry into bit 0 of the segment
//   s     : segment sum
//   co    : carry out of the segment MSB
//   c_msb : carry into the segment MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG-1:0] w_g;
  logic [SEG-1:0] w_p;
  logic [SEG:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Lookahead carries: c[i+1] = ci&p[0..i] | OR_j ( g[j] & p[j+1..i] ).
  always_comb begin
    logic w_acc;
    logic w_term;
    w_acc  = 1'b0;
    w_term = 1'b0;
    w_c    = '0;
    w_c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      w_acc = ci;
      for (int j = 0; j <= i; j++) begin
        w_acc = w_acc & w_p[j];
      end
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int m = j + 1; m <= i; m++) begin
          w_term = w_term & w_p[m];
        end
        w_acc = w_acc | w_term;
      end
      w_c[i+1] = w_acc;
    end
  end

  assign s     = w_p ^ w_c[SEG-1:0];
  assign co    = w_c[SEG];
  assign c_msb = w_c[SEG-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage k resolves segment k and registers its carry forward; operand
// segments not yet consumed ride ahead in skew registers and finished sum
// segments travel alongside, so the last stage presents an aligned result.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand beat handshake (in_ready = global advance)
//   a, b, cin, sub       : operands, carry-in (ADD only), 0=ADD 1=SUB
//   out_valid/out_ready  : result handshake
//   s, cout, ovf         : result, carry out of MSB, signed overflow
// -----------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int NBIT   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] s,
  output logic            cout,
  output logic            ovf
);

  localparam int SEG = seg_width(NBIT, STAGES);

  if (!geometry_ok(NBIT, STAGES)) begin : g_bad_geometry
    $error("cla_pipe_adder: NBIT must be a multiple of STAGES and STAGES in 1..NBIT");
  end

  // Whole pipeline moves together; it only stalls when a result is held.
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int W_IN = NBIT - k * SEG;   // operand bits still unresolved
    localparam int W_S  = (k + 1) * SEG;    // sum bits resolved so far

    logic [W_IN-1:0] w_a_in;
    logic [W_IN-1:0] w_b_in;
    logic            w_c_in;
    logic            w_v_in;
    logic [SEG-1:0]  w_seg_s;
    logic            w_seg_co;
    logic            w_seg_cmsb;
    logic [W_S-1:0]  w_s_next;

    logic            r_v;
    logic            r_c;
    logic [W_S-1:0]  r_s;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1; cin is ignored in that case.
      assign w_a_in   = a;
      assign w_b_in   = (sub == OP_SUB) ? ~b : b;
      assign w_c_in   = (sub == OP_SUB) ? 1'b1 : cin;
      assign w_v_in   = in_valid;
      assign w_s_next = w_seg_s;
    end else begin : g_body
      assign w_a_in   = g_stage[k-1].g_skew.r_a;
      assign w_b_in   = g_stage[k-1].g_skew.r_b;
      assign w_c_in   = g_stage[k-1].r_c;
      assign w_v_in   = g_stage[k-1].r_v;
      assign w_s_next = {w_seg_s, g_stage[k-1].r_s};
    end

    cla_seg #(
      .SEG (SEG)
    ) u_seg (
      .a     (w_a_in[SEG-1:0]),
      .b     (w_b_in[SEG-1:0]),
      .ci    (w_c_in),
      .s     (w_seg_s),
      .co    (w_seg_co),
      .c_msb (w_seg_cmsb)
    );

    // Stage valid, segment carry and accumulated sum register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v_in;
        r_c <= w_seg_co;
        r_s <= w_s_next;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [W_IN-SEG-1:0] r_a;
      logic [W_IN-SEG-1:0] r_b;
      // Only intermediate stages resolve carry-into-MSB of a non-top segment.
      logic w_cmsb_unused;
      assign w_cmsb_unused = w_seg_cmsb;

      // Operand segments above this stage wait one more register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a_in[W_IN-1:SEG];
          r_b <= w_b_in[W_IN-1:SEG];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Signed overflow: carry into MSB differs from carry out of MSB.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_seg_cmsb ^ w_seg_co;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign s         = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
// Three adder instances (STAGES = 4, 1, 8), each with its own driver and a
// scoreboard monitor. The driver pushes expected results as beats are
// accepted; the monitor pops and compares whenever a result transfers.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  localparam int NVEC    = 8;
  localparam int NSTREAM = 200;

  // Hand-computed directed vectors: a, b, cin, sub -> s, cout, ovf.
  localparam vec_t VECS [NVEC] = '{
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1},
    '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0},
    '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1}
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference arithmetic for random beats.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [31:0] bb;
    logic [32:0] r;
    exp_t        e;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    e.s = r[31:0];
    e.c = r[32];
    e.o = (a[31] == bb[31]) && (r[31] != a[31]);
    return e;
  endfunction

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int ST = (gi == 0) ? 4 : ((gi == 1) ? 1 : 8);

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;

    exp_t        q [$];
    exp_t        cur_exp;
    logic        armed      = 1'b0;
    logic        done       = 1'b0;
    logic        stall_prev = 1'b0;
    logic [34:0] prev       = '0;
    int          pops       = 0;

    cla_pipe_adder #(
      .NBIT   (32),
      .STAGES (ST)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
    );

    // Scoreboard monitor: stall stability, in-order compare, push on accept.
    always @(negedge clk) begin
      exp_t e;
      if (armed) begin
        if (!rst_n) begin
          q.delete();
        end else begin
          if (stall_prev)
            check1($sformatf("st%0d_stall_hold", ST), {29'd0, out_valid, s, cout, ovf}, {29'd0, prev});
          if (out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL st%0d_unexpected_output: got s=%h cout=%b ovf=%b expected none",
                       ST, s, cout, ovf);
            end else begin
              e = q.pop_front();
              check1($sformatf("st%0d_result", ST), {30'd0, s, cout, ovf}, {30'd0, e.s, e.c, e.o});
            end
          end
          if (in_valid && in_ready)
            q.push_back(cur_exp);
        end
      end
      stall_prev = rst_n && out_valid && !out_ready;
      prev       = {out_valid, s, cout, ovf};
    end

    // Issue one beat into an empty pipe and measure edges until out_valid.
    task automatic single_beat(input string name);
      int n;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 32) begin
        @(posedge clk); #1;
        n++;
      end
      check1($sformatf("st%0d_%s_latency", ST, name), n, ST - 1);
      @(posedge clk); #1;
    endtask

    initial begin
      int  issued;
      int  cyc;
      logic acc;

      // Reset held two cycles with an accepting beat offered.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      a         = 32'hFFFF_FFFF;
      b         = 32'hFFFF_FFFF;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      cur_exp   = model(a, b, cin, sub);
      @(posedge clk); #1;
      armed = 1'b1;
      check1($sformatf("st%0d_reset_cyc1", ST), {29'd0, out_valid, s, cout, ovf}, 64'd0);
      @(posedge clk); #1;
      check1($sformatf("st%0d_reset_cyc2", ST), {29'd0, out_valid, s, cout, ovf}, 64'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check1($sformatf("st%0d_ready_after_reset", ST), {62'd0, in_ready, out_valid}, 64'd2);

      // Directed vectors, one at a time.
      for (int i = 0; i < NVEC; i++) begin
        a       = VECS[i].a;
        b       = VECS[i].b;
        cin     = VECS[i].cin;
        sub     = VECS[i].sub;
        cur_exp = '{VECS[i].s, VECS[i].c, VECS[i].o};
        single_beat($sformatf("vec%0d", i));
      end

      // Random stream with random bubbles and backpressure.
      issued = 0;
      cyc    = 0;
      while (issued < NSTREAM && cyc < 5000) begin
        in_valid  = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(3) != 0);
        a         = $urandom;
        b         = $urandom;
        sub       = 1'($urandom_range(1));
        cin       = 1'($urandom_range(1));
        cur_exp   = model(a, b, cin, sub);
        #1;
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) issued++;
        cyc++;
      end
      check1($sformatf("st%0d_stream_issued", ST), issued, NSTREAM);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (q.size() != 0 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check1($sformatf("st%0d_drain_empty", ST), q.size(), 0);
      check1($sformatf("st%0d_result_count", ST), pops, NVEC + NSTREAM);

      // Reset with beats in flight: none of them may emerge.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        a        = 32'h0000_0100 * (i + 1);
        b        = 32'h0000_0003;
        cin      = 1'b0;
        sub      = 1'b0;
        cur_exp  = model(a, b, cin, sub);
        in_valid = 1'b1;
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check1($sformatf("st%0d_midreset_valid", ST), out_valid, 1'b0);
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (ST + 3) @(posedge clk);
      #1;
      a       = 32'h0000_0010;
      b       = 32'h0000_0020;
      cin     = 1'b0;
      sub     = 1'b0;
      cur_exp = '{32'h0000_0030, 1'b0, 1'b0};
      single_beat("post_reset");
      check1($sformatf("st%0d_post_reset_count", ST), pops, NVEC + NSTREAM + 1);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_dut[0].done && g_dut[1].done && g_dut[2].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check1("all_done", {61'd0, g_dut[0].done, g_dut[1].done, g_dut[2].done}, 64'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
